// File: rtl/ble_uart_rx_pkg.sv
// Shared types and constants for the BLE UART receiver.
package ble_uart_rx_pkg;

    typedef enum logic [1:0] {
        S_RX_IDLE,
        S_RX_START,
        S_RX_DATA,
        S_RX_STOP
    } uart_rx_state_t;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_MID_SAMPLE = 8;

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with registered head output; push and pop may coincide even when full.
module byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [7:0]             push_data,
    input  logic                   pop,
    output logic [7:0]             pop_data,
    output logic                   pop_valid,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= push_data;
        end
    end

    // Pointers are AW bits wide, so DEPTH being a power of two gives the wrap for free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            pop_data  <= 8'h00;
            pop_valid <= 1'b0;
        end else begin
            pop_valid <= do_pop;
            if (do_push) begin
                wptr <= wptr + AW'(1);
            end
            if (do_pop) begin
                pop_data <= mem[rptr];
                rptr     <= rptr + AW'(1);
            end
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/ble_uart_rx.sv
// 8N1 UART receiver for a BLE module link, 16x oversampled, feeding a byte FIFO.
module ble_uart_rx
    import ble_uart_rx_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rx,
    input  logic [15:0]            baud_div,
    input  logic                   get_ack_byte,
    output logic [7:0]             ack_byte,
    output logic                   ack_valid,
    output logic                   ack_ready,
    output logic                   frame_err,
    output logic                   overrun,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int         OVERSAMPLE = UART_OVERSAMPLE;
    localparam logic [3:0] MID_LAST   = 4'(UART_MID_SAMPLE - 1);
    localparam logic [3:0] BIT_LAST   = 4'(OVERSAMPLE - 1);

    uart_rx_state_t state, state_nxt;
    logic        rx_meta, rx_s, rx_prev;
    logic [15:0] div_cnt, div_lim;
    logic        tick;
    logic [3:0]  sub_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift;
    logic        sample;
    logic        push;
    logic        ferr_set;
    logic        fifo_full;
    logic        fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    // The divisor is captured only at wrap, so a new baud_div starts on a clean tick period.
    assign tick = (div_cnt == div_lim);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= 16'd0;
            div_lim <= 16'd0;
        end else if (tick) begin
            div_cnt <= 16'd0;
            div_lim <= baud_div;
        end else begin
            div_cnt <= div_cnt + 16'd1;
        end
    end

    assign sample = tick && ((state == S_RX_START) ? (sub_cnt == MID_LAST)
                                                   : (sub_cnt == BIT_LAST));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_RX_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_RX_IDLE:  if (rx_prev && !rx_s)                state_nxt = S_RX_START;
            S_RX_START: if (sample)                          state_nxt = rx_s ? S_RX_IDLE : S_RX_DATA;
            S_RX_DATA:  if (sample && (bit_cnt == 3'd7))     state_nxt = S_RX_STOP;
            S_RX_STOP:  if (sample)                          state_nxt = S_RX_IDLE;
            default:                                         state_nxt = S_RX_IDLE;
        endcase
    end

    always_comb begin
        push     = 1'b0;
        ferr_set = 1'b0;
        if (state == S_RX_STOP && sample) begin
            push     = rx_s;
            ferr_set = !rx_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_cnt <= 4'd0;
            bit_cnt <= 3'd0;
            shift   <= 8'h00;
        end else if (state == S_RX_IDLE) begin
            sub_cnt <= 4'd0;
            bit_cnt <= 3'd0;
        end else if (tick) begin
            sub_cnt <= sample ? 4'd0 : sub_cnt + 4'd1;
            if (state == S_RX_DATA && sample) begin
                shift   <= {rx_s, shift[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

    // A full FIFO is never empty, so a same-cycle pop request is always accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= ferr_set;
            overrun   <= push && fifo_full && !get_ack_byte;
        end
    end

    byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (shift),
        .pop       (get_ack_byte),
        .pop_data  (ack_byte),
        .pop_valid (ack_ready),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign ack_valid = !fifo_empty;

endmodule

// File: tb/tb_ble_uart_rx.sv
// Bench for ble_uart_rx: serial frames at baud_div=4 against a queue-based FIFO model.
module tb_ble_uart_rx;

    localparam int DEPTH    = 16;
    localparam int BIT_CLKS = 80;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic [15:0] baud_div = 16'd4;
    logic        get_ack_byte = 1'b0;
    logic [7:0]  ack_byte;
    logic        ack_valid, ack_ready, frame_err, overrun;
    logic [4:0]  fifo_count;

    int n_checks = 0;
    int n_fail   = 0;
    int n_ferr = 0, n_ovr = 0, n_rdy = 0;
    int exp_ferr = 0, exp_ovr = 0;
    logic [7:0] model_q[$];
    logic [7:0] last_ack = 8'h00;

    ble_uart_rx #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx           (rx),
        .baud_div     (baud_div),
        .get_ack_byte (get_ack_byte),
        .ack_byte     (ack_byte),
        .ack_valid    (ack_valid),
        .ack_ready    (ack_ready),
        .frame_err    (frame_err),
        .overrun      (overrun),
        .fifo_count   (fifo_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err) n_ferr++;
        if (overrun)   n_ovr++;
        if (ack_ready) n_rdy++;
    end

    initial begin
        #800_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one 8N1 frame and updates the model: good stop pushes or overruns, bad stop is a frame error.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_clks(BIT_CLKS);
        end
        rx = stop_bit;
        if (!stop_bit)                     exp_ferr++;
        else if (model_q.size() < DEPTH)   model_q.push_back(b);
        else                               exp_ovr++;
        wait_clks(BIT_CLKS);
        rx = 1'b1;
    endtask

    task automatic do_pop(output logic [7:0] got, output logic rdy, output logic rdy_next);
        @(posedge clk); #1 get_ack_byte = 1'b1;
        @(posedge clk); #1 get_ack_byte = 1'b0;
        rdy = ack_ready;
        got = ack_byte;
        @(posedge clk); #1 rdy_next = ack_ready;
    endtask

    task automatic wait_valid(input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge clk); #1;
            ok = ack_valid;
        end
    endtask

    task automatic drain_and_compare(input string name);
        logic [7:0] got, exp;
        logic rdy, rdyn;
        while (model_q.size() > 0) begin
            exp = model_q.pop_front();
            do_pop(got, rdy, rdyn);
            last_ack = exp;
            n_checks++;
            if (rdy !== 1'b1 || got !== exp || rdyn !== 1'b0) begin
                n_fail++;
                $display("FAIL %s pop: got byte=%h ready=%b next_ready=%b, required byte=%h ready=1 next_ready=0",
                         name, got, rdy, rdyn, exp);
            end
        end
        n_checks++;
        if (fifo_count !== 5'd0 || ack_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s drained: fifo_count=%0d ack_valid=%b, required 0/0", name, fifo_count, ack_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wait_clks(3);
        n_checks++;
        if (ack_byte !== 8'h00 || ack_valid !== 1'b0 || ack_ready !== 1'b0 ||
            frame_err !== 1'b0 || overrun !== 1'b0 || fifo_count !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_values: byte=%h valid=%b ready=%b ferr=%b ovr=%b count=%0d, required all zero",
                     ack_byte, ack_valid, ack_ready, frame_err, overrun, fifo_count);
        end
        rst_n = 1'b1;
        wait_clks(10);
    endtask

    task automatic test_single();
        logic [7:0] got, exp;
        logic rdy, rdyn;
        send_frame(8'h4F, 1'b1);
        wait_clks(2);
        n_checks++;
        if (ack_valid !== 1'b1 || fifo_count !== 5'd1) begin
            n_fail++;
            $display("FAIL single_queued: ack_valid=%b fifo_count=%0d, required 1/1", ack_valid, fifo_count);
        end
        exp = model_q.pop_front();
        do_pop(got, rdy, rdyn);
        last_ack = exp;
        n_checks++;
        if (rdy !== 1'b1 || got !== exp || rdyn !== 1'b0) begin
            n_fail++;
            $display("FAIL single_pop: byte=%h ready=%b next_ready=%b, required %h/1/0", got, rdy, rdyn, exp);
        end
        n_checks++;
        if (fifo_count !== 5'd0 || ack_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_after_pop: fifo_count=%0d ack_valid=%b, required 0/0", fifo_count, ack_valid);
        end
    endtask

    task automatic test_empty_pop();
        int rdy_before = n_rdy;
        @(posedge clk); #1 get_ack_byte = 1'b1;
        @(posedge clk); #1 get_ack_byte = 1'b0;
        wait_clks(2);
        n_checks++;
        if (n_rdy != rdy_before || ack_byte !== last_ack) begin
            n_fail++;
            $display("FAIL empty_pop: ready pulses=%0d byte=%h, required 0 pulses and byte %h",
                     n_rdy - rdy_before, ack_byte, last_ack);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] msg [9] = '{8'h4F, 8'h4B, 8'h2B, 8'h43, 8'h4F, 8'h4E, 8'h4E, 8'h0D, 8'h0A};
        logic [7:0] got_q[$];
        fork
            begin
                for (int i = 0; i < 9; i++) send_frame(msg[i], 1'b1);
            end
            begin
                logic ok, rdy, rdyn;
                logic [7:0] got;
                for (int i = 0; i < 9; i++) begin
                    wait_valid(1500, ok);
                    if (!ok) begin
                        n_checks++; n_fail++;
                        $display("FAIL b2b_timeout: byte %0d never became valid", i);
                        break;
                    end
                    do_pop(got, rdy, rdyn);
                    got_q.push_back(got);
                    n_checks++;
                    if (rdy !== 1'b1 || rdyn !== 1'b0) begin
                        n_fail++;
                        $display("FAIL b2b_ready: byte %0d ready=%b next_ready=%b, required 1/0", i, rdy, rdyn);
                    end
                end
            end
        join
        for (int i = 0; i < got_q.size(); i++) begin
            logic [7:0] exp = model_q.pop_front();
            n_checks++;
            if (got_q[i] !== exp) begin
                n_fail++;
                $display("FAIL b2b_data[%0d]: got %h, required %h", i, got_q[i], exp);
            end
            last_ack = exp;
        end
        n_checks++;
        if (n_ferr != exp_ferr || n_ovr != exp_ovr) begin
            n_fail++;
            $display("FAIL b2b_errors: ferr=%0d ovr=%0d, required %0d/%0d", n_ferr, n_ovr, exp_ferr, exp_ovr);
        end
    endtask

    task automatic test_overrun();
        for (int i = 0; i <= 16; i++) send_frame(8'(i), 1'b1);
        wait_clks(2);
        n_checks++;
        if (fifo_count !== 5'd16 || ack_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_full: fifo_count=%0d ack_valid=%b, required 16/1", fifo_count, ack_valid);
        end
        n_checks++;
        if (n_ovr != exp_ovr) begin
            n_fail++;
            $display("FAIL overrun_pulse: pulses=%0d, required %0d", n_ovr, exp_ovr);
        end
        drain_and_compare("overrun");
    endtask

    task automatic test_frame_err();
        send_frame(8'($urandom_range(255)), 1'b0);
        wait_clks(4);
        n_checks++;
        if (n_ferr != exp_ferr || fifo_count !== 5'd0 || ack_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_err: pulses=%0d count=%0d valid=%b, required %0d/0/0",
                     n_ferr, fifo_count, ack_valid, exp_ferr);
        end
    endtask

    task automatic test_glitch();
        int rdy_before = n_rdy;
        rx = 1'b0;
        wait_clks(15);
        rx = 1'b1;
        wait_clks(2 * BIT_CLKS);
        n_checks++;
        if (fifo_count !== 5'd0 || n_ferr != exp_ferr || n_ovr != exp_ovr || n_rdy != rdy_before) begin
            n_fail++;
            $display("FAIL glitch: count=%0d ferr=%0d ovr=%0d ready=%0d, required 0/%0d/%0d/0",
                     fifo_count, n_ferr, n_ovr, n_rdy - rdy_before, exp_ferr, exp_ovr);
        end
        send_frame(8'($urandom_range(255)), 1'b1);
        drain_and_compare("after_glitch");
    endtask

    task automatic test_reset_midframe();
        logic [7:0] b = 8'($urandom_range(255));
        for (int i = 0; i < 3; i++) send_frame(8'($urandom_range(255)), 1'b1);
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            wait_clks(BIT_CLKS);
        end
        rx = b[4];
        wait_clks(BIT_CLKS / 2);
        rst_n = 1'b0;
        model_q.delete();
        last_ack = 8'h00;
        wait_clks(5);
        n_checks++;
        if (ack_byte !== 8'h00 || ack_valid !== 1'b0 || ack_ready !== 1'b0 ||
            frame_err !== 1'b0 || overrun !== 1'b0 || fifo_count !== 5'd0) begin
            n_fail++;
            $display("FAIL midframe_reset: byte=%h valid=%b ready=%b ferr=%b ovr=%b count=%0d, required all zero",
                     ack_byte, ack_valid, ack_ready, frame_err, overrun, fifo_count);
        end
        rx = 1'b1;
        wait_clks(5);
        rst_n = 1'b1;
        wait_clks(3 * BIT_CLKS);
        n_checks++;
        if (n_ferr != exp_ferr || n_ovr != exp_ovr || fifo_count !== 5'd0) begin
            n_fail++;
            $display("FAIL midframe_after: ferr=%0d ovr=%0d count=%0d, required %0d/%0d/0",
                     n_ferr, n_ovr, fifo_count, exp_ferr, exp_ovr);
        end
        send_frame(8'h41, 1'b1);
        drain_and_compare("post_reset_41");
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            send_frame(8'($urandom_range(255)), ($urandom_range(3) != 0));
            wait_clks($urandom_range(100));
        end
        n_checks++;
        if (fifo_count !== 5'(model_q.size()) || n_ferr != exp_ferr || n_ovr != exp_ovr) begin
            n_fail++;
            $display("FAIL random_state: count=%0d ferr=%0d ovr=%0d, required %0d/%0d/%0d",
                     fifo_count, n_ferr, n_ovr, model_q.size(), exp_ferr, exp_ovr);
        end
        drain_and_compare("random");
    endtask

    initial begin
        test_reset();
        test_single();
        test_empty_pop();
        test_back_to_back();
        test_overrun();
        test_frame_err();
        test_glitch();
        test_reset_midframe();
        test_random();
        test_empty_pop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ble_uart_rx.md
BLE_UART_RX -- requirements
Module: ble_uart_rx

Interface
REQ-001 Parameter: DEPTH, 16, FIFO depth in bytes; power of two, 4..64.
REQ-002 Parameter: OVERSAMPLE, 16, sample ticks per bit; fixed, not overridable by instantiation.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 rx  input  1  serial line from BLE module TX; idle high; asynchronous to clk.
REQ-006 baud_div  input  16  sample-tick divider; one tick every baud_div+1 clocks.
REQ-007 ack_byte  output  8  FIFO head byte delivered by the last pop.
REQ-008 ack_valid  output  1  level; high while FIFO holds at least one byte.
REQ-009 get_ack_byte  input  1  one-cycle pop request from the consumer.
REQ-010 ack_ready  output  1  one-cycle pulse; ack_byte is valid in this cycle.
REQ-011 frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-012 overrun  output  1  one-cycle pulse when a received byte is dropped because the FIFO is full.
REQ-013 fifo_count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-014 rx passes through a 2-flop synchronizer before use; all rx decisions use the synchronized value.
REQ-015 Tick counter counts 0..baud_div, wraps, and issues a tick at count==baud_div; it runs continuously.
REQ-016 Receiver FSM states are IDLE, START, DATA and STOP.
REQ-017 IDLE: on a synchronized rx high-to-low transition, go to START and zero the tick count within the bit.
REQ-018 START: after 8 ticks, resample rx; if low go to DATA, if high (glitch) return to IDLE with no output.
REQ-019 DATA: sample every 16 ticks, 8 bits, LSB first, into a shift register; after bit 7 go to STOP.
REQ-020 STOP: sample after 16 ticks; if high, push the byte; if low, pulse frame_err, discard the byte and return to IDLE.
REQ-021 A push sets the FIFO write side; the byte is visible on ack_valid and fifo_count the cycle after the STOP sample.
REQ-022 get_ack_byte with FIFO non-empty pops the head: the next cycle ack_byte=head and ack_ready=1 for exactly one cycle, and fifo_count decrements.
REQ-023 get_ack_byte with FIFO empty is ignored: no ack_ready, ack_byte holds its value.
REQ-024 ack_byte holds its value between pops.
REQ-025 Push while full without a same-cycle pop: drop the byte, pulse overrun, contents unchanged.
REQ-026 Push and pop in the same cycle: both succeed even when full; fifo_count is unchanged.
REQ-027 Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
REQ-028 A baud_div change takes effect at the next tick-counter wrap; a frame in progress may be corrupted.

Reset
REQ-029 While rst_n is low: FSM=IDLE, pointers=0, fifo_count=0, ack_byte=8'h00, ack_valid=0, ack_ready=0, frame_err=0, overrun=0, synchronizer flops=1.
REQ-030 Reset asserted mid-frame aborts the frame, flushes the FIFO and produces no pulse outputs.

Structure
REQ-031 Shared package ble_uart_rx_pkg holds enum uart_rx_state_t (S_RX_IDLE, S_RX_START, S_RX_DATA, S_RX_STOP) and constants UART_OVERSAMPLE=16 and UART_MID_SAMPLE=8.
REQ-032 The FIFO is one sub-module, byte_fifo (parameter DEPTH; push/pop/full/empty/count), instantiated once.

Verification (baud_div=4, so 80 clocks per bit)
REQ-033 Send 0x4F with a valid stop bit, then one get_ack_byte pulse: ack_valid rises, then ack_byte=0x4F with ack_ready high for 1 cycle, fifo_count goes 1 to 0.
REQ-034 Send "OK+CONN\r\n" back to back, popping each byte on ack_valid: ack_ready delivers 4F 4B 2B 43 4F 4E 4E 0D 0A in order, with no frame_err and no overrun.
REQ-035 Send 17 bytes 0x00..0x10 with no pops: fifo_count=16, one overrun pulse on the 17th; subsequent pops return 0x00..0x0F.
REQ-036 Send a frame with the stop bit held low: one frame_err pulse, fifo_count unchanged, ack_valid stays low.
REQ-037 Drive rx low for 3 ticks, then high: FSM returns to IDLE, and no byte, frame_err or overrun is produced.
REQ-038 Assert rst_n low during data bit 4 with 3 bytes queued: all outputs return to reset values, and a following clean 0x41 frame is received correctly.
